// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit with sub-word read-modify-write to a synchronous data RAM.
module mem_access_unit #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [5:0]        opcode,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata_in,
  output logic [31:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d, mem_data_q, mem_data_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d, we_q, we_d;
  logic        legal, bad;
  logic [4:0]  lane, hsh;
  logic [31:0] rd_b, rd_h, ld_v, mask, ins;
  // op[1:0] encodes size (00 byte, 01 half, 11 word), op[2] unsigned, op[3] store
  always_comb begin
    legal = opcode inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                           6'b101000, 6'b101001, 6'b101011};
    bad = !legal || (opcode[1:0] == 2'b01 && addr[0]) || (opcode[1:0] == 2'b11 && addr[1:0] != 2'b00);
    lane = {addr_q[1:0], 3'b000};
    hsh = {addr_q[1], 4'b0000};
    rd_b = ram_rdata >> lane;
    rd_h = ram_rdata >> hsh;
    ld_v = op_q[1:0] == 2'b11 ? ram_rdata
         : op_q[0] ? {{16{!op_q[2] && rd_h[15]}}, rd_h[15:0]}
         : {{24{!op_q[2] && rd_b[7]}}, rd_b[7:0]};
    mask = op_q[0] ? 32'h0000FFFF << hsh : 32'h000000FF << lane;
    ins = op_q[0] ? {16'b0, wdata_q[15:0]} << hsh : {24'b0, wdata_q[7:0]} << lane;
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    word_d = word_q;
    mem_data_d = mem_data_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req) begin
        op_d = opcode;
        addr_d = addr;
        wdata_d = wdata_in;
        err_d = bad;
        state_d = bad ? DONE : opcode == 6'b101011 ? WRITE : READ;
      end
      READ: state_d = WAIT;
      WAIT: if (op_q[3]) begin
        word_d = (ram_rdata & ~mask) | ins;
        state_d = WRITE;
      end else begin
        mem_data_d = ld_v;
        state_d = DONE;
      end
      WRITE: state_d = DONE;
      DONE: begin
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    we_d = state_d == WRITE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      word_q <= '0;
      mem_data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      word_q <= word_d;
      mem_data_q <= mem_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      we_q <= we_d;
    end
  end
  assign mem_data = mem_data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign ram_addr = addr_q[ADDR_W+1:2];
  assign ram_we = we_q && !reset;
  assign ram_wdata = op_q[1:0] == 2'b11 ? wdata_q : word_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of loads, sub-word stores, errors, req handling and reset abort.
module tb_mem_access_unit;
  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100,
                         LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
  logic        clock = 0, reset = 1, req = 0;
  logic [5:0]  opcode = 0;
  logic [31:0] addr = 0, wdata_in = 0, mem_data, ram_wdata, ram_rdata;
  logic        busy, done, err, ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram [0:16383];
  int          n_chk = 0, n_pass = 0, we_cnt = 0, lat, w0, dn;
  logic        bz;

  mem_access_unit #(.ADDR_W(14)) dut (
    .clock(clock), .reset(reset), .req(req), .opcode(opcode), .addr(addr),
    .wdata_in(wdata_in), .mem_data(mem_data), .busy(busy), .done(done), .err(err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      we_cnt <= we_cnt + 1;
    end
    ram_rdata <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic start(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clock);
    opcode = op;
    addr = a;
    wdata_in = wd;
    req = 1;
    @(posedge clock);
    #1 req = 0;
  endtask

  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                     output int l, output logic b);
    start(op, a, wd);
    l = 0;
    b = 1;
    do begin
      @(negedge clock);
      l++;
      if (!busy) b = 0;
    end while (!done && l < 20);
  endtask

  initial begin
    ram[0] = 32'h8899AABB;
    ram[1] = 32'h11111111;
    ram[2] = 32'h5A5A5A5A;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 0;
    @(negedge clock);
    check("rst_out", {mem_data[31:0], 27'b0, busy, done, err, ram_we}, 64'h0);
    check("rst_busy", {31'b0, busy}, 0);

    run(LW, 0, 0, lat, bz);
    check("lw_data", mem_data, 32'h8899AABB);
    check("lw_lat", lat, 3);
    check("lw_busy", {31'b0, bz}, 1);
    check("lw_err", {31'b0, err}, 0);
    @(negedge clock);
    check("idle_busy", {30'b0, busy, done}, 0);

    run(LB, 1, 0, lat, bz);
    check("lb1", mem_data, 32'hFFFFFFAA);
    run(LBU, 1, 0, lat, bz);
    check("lbu1", mem_data, 32'h000000AA);
    run(LHU, 2, 0, lat, bz);
    check("lhu2", mem_data, 32'h00008899);
    run(LH, 2, 0, lat, bz);
    check("lh2", mem_data, 32'hFFFF8899);
    check("lh_lat", lat, 3);

    w0 = we_cnt;
    run(SH, 2, 32'hDEAD1234, lat, bz);
    check("sh_ram", ram[0], 32'h1234AABB);
    check("sh_lat", lat, 4);
    check("sh_we", we_cnt - w0, 1);
    check("st_keep", mem_data, 32'hFFFF8899);
    run(SB, 0, 32'h00000077, lat, bz);
    check("sb_ram", ram[0], 32'h1234AA77);
    run(LB, 3, 0, lat, bz);
    check("lb3", mem_data, 32'h00000012);
    run(LW, 32'h0001_0000, 0, lat, bz);
    check("wrap", mem_data, 32'h1234AA77);

    w0 = we_cnt;
    run(SW, 4, 32'hCAFEBABE, lat, bz);
    check("sw_lat", lat, 2);
    check("sw_ram", ram[1], 32'hCAFEBABE);
    check("sw_we", we_cnt - w0, 1);
    w0 = we_cnt;
    run(SW, 5, 32'h0BADF00D, lat, bz);
    check("sw5_err", {31'b0, err}, 1);
    check("sw5_lat", lat, 1);
    check("sw5_we", we_cnt - w0, 0);
    run(LH, 3, 0, lat, bz);
    check("lh3_err", {31'b0, err}, 1);
    check("lh3_keep", mem_data, 32'h1234AA77);
    run(6'b000000, 0, 0, lat, bz);
    check("ill_err", {31'b0, err}, 1);
    run(LW, 0, 0, lat, bz);
    check("err_clr", {31'b0, err}, 0);

    w0 = we_cnt;
    dn = 0;
    start(LW, 4, 0);
    @(negedge clock);
    opcode = SW;
    addr = 8;
    wdata_in = 32'hFFFFFFFF;
    req = 1;
    @(posedge clock);
    #1 req = 0;
    repeat (10) begin
      @(negedge clock);
      if (done) dn++;
    end
    check("busy_req_dn", dn, 1);
    check("busy_req_we", we_cnt - w0, 0);
    check("busy_req_dat", mem_data, 32'hCAFEBABE);

    run(LW, 0, 0, lat, bz);
    opcode = LHU;
    addr = 0;
    req = 1;
    @(negedge clock);
    check("done_req_ign", {31'b0, busy}, 0);
    @(posedge clock);
    #1 req = 0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!done && lat < 20);
    check("b2b_lat", lat, 3);
    check("b2b_dat", mem_data, 32'h0000AA77);

    w0 = we_cnt;
    start(SB, 8, 32'h00000055);
    repeat (3) @(negedge clock);
    check("in_write", {31'b0, ram_we}, 1);
    reset = 1;
    @(negedge clock);
    reset = 0;
    check("rst_abort", {mem_data, 28'b0, busy, done, err, ram_we}, 64'h0);
    check("rst_ram", ram[2], 32'h5A5A5A5A);
    check("rst_we", we_cnt - w0, 0);
    run(LW, 8, 0, lat, bz);
    check("post_rst", mem_data, 32'h5A5A5A5A);
    check("post_lat", lat, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
